// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg : shared types and constants for the fetch/data SRAM arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } arb_owner_e;

  localparam int unsigned c_default_sram_wait = 3;

  // The counter only ever holds SRAM_WAIT-1 down to 0.
  function automatic int unsigned cnt_width(input int unsigned wait_cycles);
    return (wait_cycles > 1) ? $clog2(wait_cycles) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_wait_counter.sv
// ----------------------------------------------------------------------------
// sram_wait_counter : loadable down-counter flagging the last SRAM access cycle
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sram_wait_counter #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter : shares one multi-cycle SRAM between fetch and data ports
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned SRAM_WAIT = c_default_sram_wait
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-3:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              freeze
);

  localparam int unsigned          CNT_W      = cnt_width(SRAM_WAIT);
  localparam logic [CNT_W-1:0]     c_cnt_load = CNT_W'(SRAM_WAIT - 1);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic [ADDR_W-3:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              mem_req;
  logic              cnt_load;
  logic              cnt_zero;
  logic              unused_byte_bits;

  assign mem_req          = mem_r_en | mem_w_en;
  assign unused_byte_bits = ^{if_addr[1:0], mem_addr[1:0]};

  sram_wait_counter #(
    .WIDTH (CNT_W)
  ) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (c_cnt_load),
    .dec      (state_q == ACCESS),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    cnt_load    = 1'b0;
    case (state_q)
      IDLE: begin
        // Data port has strict priority; a simultaneous read+write is a write.
        if (mem_req) begin
          state_d  = ACCESS;
          owner_d  = OWN_MEM;
          addr_d   = mem_addr[ADDR_W-1:2];
          we_d     = mem_w_en;
          wdata_d  = mem_wdata;
          cnt_load = 1'b1;
        end else if (if_req) begin
          state_d  = ACCESS;
          owner_d  = OWN_IF;
          addr_d   = if_addr[ADDR_W-1:2];
          we_d     = 1'b0;
          cnt_load = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt_zero) begin
          state_d = DONE;
          if (!we_q) begin
            if (owner_q == OWN_IF) begin
              if_rdata_d = sram_rdata;
            end else begin
              mem_rdata_d = sram_rdata;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign sram_en    = (state_q == ACCESS);
  assign sram_we    = (state_q == ACCESS) & we_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign if_rdata   = if_rdata_q;
  assign mem_rdata  = mem_rdata_q;
  assign if_ready   = (state_q == DONE) & (owner_q == OWN_IF);
  assign mem_ready  = (state_q == DONE) & (owner_q == OWN_MEM);

  assign freeze = ~rst & ((if_req & ~if_ready) | (mem_req & ~mem_ready));

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter : self-checking bench with a transaction-level model
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_mem_port_arbiter;

  localparam int unsigned W = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- instance with SRAM_WAIT = 3 ----------------
  logic        if_req, mem_r_en, mem_w_en;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [31:0] if_rdata, mem_rdata, sram_wdata, sram_rdata;
  logic        if_ready, mem_ready, sram_en, sram_we, freeze;
  logic [29:0] sram_addr;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .SRAM_WAIT(W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .freeze(freeze)
  );

  // SRAM model: data only valid in the last access cycle, inverted otherwise
  logic [31:0] sram_mem [0:255];
  int          acc_idx = 0;
  always @(posedge clk) acc_idx <= sram_en ? acc_idx + 1 : 0;
  always @(posedge clk)
    if (sram_en && sram_we && acc_idx == W - 1) sram_mem[sram_addr[7:0]] <= sram_wdata;
  assign sram_rdata = (sram_en && !sram_we && acc_idx == W - 1) ?
                      sram_mem[sram_addr[7:0]] : ~sram_mem[sram_addr[7:0]];

  // ---------------- instance with SRAM_WAIT = 1 ----------------
  logic        if_req2, mem_r_en2, mem_w_en2;
  logic [31:0] if_addr2, mem_addr2, mem_wdata2;
  logic [31:0] if_rdata2, mem_rdata2, sram_wdata2, sram_rdata2;
  logic        if_ready2, mem_ready2, sram_en2, sram_we2, freeze2;
  logic [29:0] sram_addr2;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .SRAM_WAIT(1)) dut2 (
    .clk(clk), .rst(rst),
    .if_req(if_req2), .if_addr(if_addr2), .if_rdata(if_rdata2), .if_ready(if_ready2),
    .mem_r_en(mem_r_en2), .mem_w_en(mem_w_en2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .mem_ready(mem_ready2),
    .sram_en(sram_en2), .sram_we(sram_we2), .sram_addr(sram_addr2),
    .sram_wdata(sram_wdata2), .sram_rdata(sram_rdata2), .freeze(freeze2)
  );

  assign sram_rdata2 = {sram_addr2, 2'b11} ^ 32'h5A5A_5A5A;

  function automatic logic [31:0] f2(input logic [31:0] byte_addr);
    return {byte_addr[31:2], 2'b11} ^ 32'h5A5A_5A5A;
  endfunction

  // ---------------- reference model state ----------------
  logic [31:0] model_mem [0:255];
  logic [31:0] exp_if_q;
  logic [31:0] exp_mem_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b1; mem_w_en = 1'b1; mem_addr = 32'h1234_5678; mem_wdata = 32'hFFFF_FFFF;
    tick(); tick();
    @(negedge clk);
    checks++;
    if ({if_ready, mem_ready, sram_en, sram_we, freeze} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 00000", {if_ready, mem_ready, sram_en, sram_we, freeze});
    end
    checks++;
    if ({if_rdata, mem_rdata, sram_addr, sram_wdata} !== '0) begin
      errors++; $display("FAIL reset_data got %h %h %h %h exp 0", if_rdata, mem_rdata, sram_addr, sram_wdata);
    end
    tick();
    rst = 1'b0; if_req = 1'b0; mem_w_en = 1'b0; mem_wdata = '0;
    @(negedge clk);
    checks++;
    if ({sram_en, freeze, if_ready, mem_ready} !== 4'b0) begin
      errors++; $display("FAIL reset_idle got %b exp 0000", {sram_en, freeze, if_ready, mem_ready});
    end
    tick();
  endtask

  // Runs one request set starting from an idle arbiter and checks every cycle.
  task automatic run_case(input string name, input bit do_if, input logic [31:0] ia,
                          input bit m_re, input bit m_we, input logic [31:0] ma,
                          input logic [31:0] wd, input int drop_c);
    bit do_mem, if_on, mem_on, in_if, in_mem, e_rif, e_rmem, e_frz;
    int g_if, r_if, r_mem, last;
    do_mem = m_re | m_we;
    g_if   = do_mem ? W + 2 : 0;
    r_mem  = do_mem ? W + 1 : -100;
    r_if   = do_if ? g_if + W + 1 : -100;
    last   = ((r_mem > r_if) ? r_mem : r_if) + 2;
    if_addr = ia; mem_addr = ma; mem_wdata = wd;
    for (int c = 0; c <= last; c++) begin
      if_on    = do_if && c <= r_if && (drop_c < 0 || c < drop_c);
      mem_on   = do_mem && c <= r_mem && (drop_c < 0 || c < drop_c);
      if_req   = if_on;
      mem_r_en = mem_on & m_re;
      mem_w_en = mem_on & m_we;
      @(negedge clk);
      in_mem = do_mem && c >= 1 && c <= W;
      in_if  = do_if && c >= g_if + 1 && c <= g_if + W;
      e_rif  = (c == r_if);
      e_rmem = (c == r_mem);
      e_frz  = (if_on && !e_rif) || (mem_on && !e_rmem);
      if (e_rmem) begin
        if (m_we) model_mem[ma[9:2]] = wd;
        else      exp_mem_q = model_mem[ma[9:2]];
      end
      if (e_rif) exp_if_q = model_mem[ia[9:2]];
      checks++;
      if (sram_en !== (in_mem || in_if)) begin
        errors++; $display("FAIL %s c%0d sram_en got %b exp %b", name, c, sram_en, in_mem || in_if);
      end
      checks++;
      if (sram_we !== (in_mem && m_we)) begin
        errors++; $display("FAIL %s c%0d sram_we got %b exp %b", name, c, sram_we, in_mem && m_we);
      end
      if (in_mem || in_if) begin
        checks++;
        if (sram_addr !== (in_mem ? ma[31:2] : ia[31:2])) begin
          errors++; $display("FAIL %s c%0d sram_addr got %h exp %h", name, c, sram_addr, in_mem ? ma[31:2] : ia[31:2]);
        end
      end
      if (in_mem && m_we) begin
        checks++;
        if (sram_wdata !== wd) begin
          errors++; $display("FAIL %s c%0d sram_wdata got %h exp %h", name, c, sram_wdata, wd);
        end
      end
      checks++;
      if ({if_ready, mem_ready} !== {e_rif, e_rmem}) begin
        errors++; $display("FAIL %s c%0d ready(if,mem) got %b%b exp %b%b", name, c, if_ready, mem_ready, e_rif, e_rmem);
      end
      checks++;
      if (freeze !== e_frz) begin
        errors++; $display("FAIL %s c%0d freeze got %b exp %b", name, c, freeze, e_frz);
      end
      checks++;
      if (if_rdata !== exp_if_q || mem_rdata !== exp_mem_q) begin
        errors++; $display("FAIL %s c%0d rdata(if,mem) got %h %h exp %h %h", name, c, if_rdata, mem_rdata, exp_if_q, exp_mem_q);
      end
      tick();
    end
    if_req = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
  endtask

  task automatic test_fetch_only();
    sram_mem[8'h10] <= 32'hE3A01005;
    model_mem[8'h10] = 32'hE3A01005;
    tick();
    run_case("fetch_only", 1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0, 32'h0, -1);
  endtask

  task automatic test_simultaneous();
    run_case("simul_if_load", 1'b1, 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0084, 32'h0, -1);
  endtask

  task automatic test_store_load();
    run_case("store", 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0104, 32'hDEADBEEF, -1);
    run_case("load_after_store", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0104, 32'h0, -1);
    checks++;
    if (mem_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL load_0x104 got %h exp deadbeef", mem_rdata);
    end
  endtask

  task automatic test_random();
    logic [31:0] ia, ma, wd;
    int kind;
    for (int n = 0; n < 24; n++) begin
      ia = $urandom; ia = ia & 32'hFFFF_F03C;
      ma = $urandom; ma = ma & 32'hFFFF_F03C;
      wd = $urandom;
      kind = $urandom_range(0, 5);
      case (kind)
        0: run_case("rnd_fetch",   1'b1, ia, 1'b0, 1'b0, ma, wd, -1);
        1: run_case("rnd_load",    1'b0, ia, 1'b1, 1'b0, ma, wd, -1);
        2: run_case("rnd_store",   1'b0, ia, 1'b0, 1'b1, ma, wd, -1);
        3: run_case("rnd_rw_both", 1'b0, ia, 1'b1, 1'b1, ma, wd, -1);
        4: run_case("rnd_if_load", 1'b1, ia, 1'b1, 1'b0, ma, wd, -1);
        default: run_case("rnd_if_store", 1'b1, ia, 1'b0, 1'b1, ma, wd, -1);
      endcase
    end
  endtask

  task automatic test_drop();
    run_case("drop_fetch", 1'b1, 32'hABCD_0018, 1'b0, 1'b0, 32'h0, 32'h0, 2);
    run_case("drop_load",  1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0024, 32'h0, 3);
  endtask

  task automatic test_reset_mid_access();
    if_addr = 32'h0000_0008;
    for (int c = 0; c <= 5; c++) begin
      if_req = (c <= 2);
      rst    = (c == 2);
      @(negedge clk);
      if (c == 1 || c == 2) begin
        checks++;
        if (sram_en !== 1'b1) begin
          errors++; $display("FAIL rst_mid c%0d sram_en got %b exp 1", c, sram_en);
        end
      end
      if (c == 2) begin
        checks++;
        if (freeze !== 1'b0) begin
          errors++; $display("FAIL rst_mid c2 freeze got %b exp 0", freeze);
        end
      end
      if (c >= 3) begin
        checks++;
        if ({sram_en, sram_we, if_ready, mem_ready} !== 4'b0) begin
          errors++; $display("FAIL rst_mid c%0d flags got %b exp 0000", c, {sram_en, sram_we, if_ready, mem_ready});
        end
        checks++;
        if ({if_rdata, mem_rdata} !== 64'h0) begin
          errors++; $display("FAIL rst_mid c%0d rdata got %h %h exp 0", c, if_rdata, mem_rdata);
        end
      end
      tick();
    end
    exp_if_q = '0; exp_mem_q = '0;
    run_case("after_reset", 1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0, 32'h0, -1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, f;
    bit er_m, er_i;
    a = 32'h1000_0010; b = 32'h2000_0020; f = 32'h3000_0030;
    for (int c = 0; c <= 9; c++) begin
      mem_r_en2 = (c <= 5);
      mem_addr2 = (c <= 2) ? a : b;
      if_req2   = (c <= 8);
      if_addr2  = f;
      @(negedge clk);
      er_m = (c == 2 || c == 5);
      er_i = (c == 8);
      checks++;
      if ({if_ready2, mem_ready2} !== {er_i, er_m}) begin
        errors++; $display("FAIL b2b c%0d ready(if,mem) got %b%b exp %b%b", c, if_ready2, mem_ready2, er_i, er_m);
      end
      checks++;
      if (sram_en2 !== (c == 1 || c == 4 || c == 7)) begin
        errors++; $display("FAIL b2b c%0d sram_en got %b", c, sram_en2);
      end
      if (c == 2 || c == 5) begin
        checks++;
        if (mem_rdata2 !== f2(c == 2 ? a : b)) begin
          errors++; $display("FAIL b2b c%0d mem_rdata got %h exp %h", c, mem_rdata2, f2(c == 2 ? a : b));
        end
      end
      if (c == 8) begin
        checks++;
        if (if_rdata2 !== f2(f)) begin
          errors++; $display("FAIL b2b c8 if_rdata got %h exp %h", if_rdata2, f2(f));
        end
      end
      tick();
    end
    mem_r_en2 = 1'b0; if_req2 = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    rst = 1'b1;
    if_req = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0;
    if_req2 = 1'b0; mem_r_en2 = 1'b0; mem_w_en2 = 1'b0;
    if_addr2 = '0; mem_addr2 = '0; mem_wdata2 = '0;
    exp_if_q = '0; exp_mem_q = '0;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      sram_mem[i] <= v;
      model_mem[i] = v;
    end
    tick();
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_store_load();
    test_random();
    test_drop();
    test_reset_mid_access();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares one multi-cycle single-port SRAM between the fetch stage (instruction reads) and the memory stage (data loads/stores).
- Serialises accesses with a small FSM and returns data through per-requester registers.
- Drives a global `freeze` that stalls every pipeline register while any request is outstanding.
- Sits between stage 1 / stage 4 and the external SRAM model.

## Interface

Parameters
- `ADDR_W`, 32: byte-address width from both requesters.
- `DATA_W`, 32: data width.
- `SRAM_WAIT`, 3: SRAM access cycles; legal range ≥1.

Ports
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset. Synchronous, active-high.
- `if_req`  in  1: fetch read request; held until `if_ready`.
- `if_addr`  in  ADDR_W: fetch byte address.
- `if_rdata`  out  DATA_W: fetched word; valid when `if_ready`.
- `if_ready`  out  1: one-cycle completion pulse for fetch.
- `mem_r_en`  in  1: data-read request.
- `mem_w_en`  in  1: data-write request.
- `mem_addr`  in  ADDR_W: data byte address.
- `mem_wdata`  in  DATA_W: store data.
- `mem_rdata`  out  DATA_W: load data; valid when `mem_ready`.
- `mem_ready`  out  1: one-cycle completion pulse for the data port.
- `sram_en`  out  1: SRAM access active.
- `sram_we`  out  1: SRAM write strobe.
- `sram_addr`  out  ADDR_W-2: SRAM word address (byte address bits [ADDR_W-1:2]).
- `sram_wdata`  out  DATA_W: SRAM write data.
- `sram_rdata`  in  DATA_W: SRAM read data; valid in the last ACCESS cycle.
- `freeze`  out  1: pipeline stall.

## Operation

- FSM states: IDLE, ACCESS, DONE.
- IDLE, arbitration:
  - A data request (`mem_r_en|mem_w_en`) wins.
  - Otherwise `if_req` wins.
  - Otherwise stay in IDLE.
- On grant:
  - Latch owner, word address, write flag and wdata.
  - Load `cnt = SRAM_WAIT-1`.
  - Go to ACCESS.
- `mem_r_en` and `mem_w_en` both high is treated as a write.
- ACCESS:
  - `sram_en=1`; `sram_addr` and `sram_wdata` come from the latched values.
  - `sram_we=1` only for a write.
  - If `cnt!=0`, decrement.
  - If `cnt==0`, capture `sram_rdata` into the owner's rdata register (read only), then go to DONE.
- DONE:
  - Pulse the owner's ready.
  - Go to IDLE unconditionally; there is no arbitration in DONE.
- The non-owner's rdata register holds its value. Writes never modify `mem_rdata`.
- `freeze = ~rst & ((if_req & ~if_ready) | ((mem_r_en|mem_w_en) & ~mem_ready))`. This is combinational.
- Priority is strict (data over fetch). Starvation is impossible because the pipeline is frozen while a data request is pending.
- If a request drops during ACCESS, the access still completes and the ready pulse is issued; the requester ignores it. The latched address is not re-sampled.

## Timing

- Request sampled in IDLE at cycle t:
  - ACCESS occupies cycles t+1 .. t+SRAM_WAIT.
  - DONE (ready=1, rdata valid) at t+SRAM_WAIT+1.
  - Earliest next grant at t+SRAM_WAIT+2.
- Latency from request to ready is SRAM_WAIT+1 cycles. Throughput is one access per SRAM_WAIT+2 cycles.
- Both ready pulses are exactly one cycle and never high together.
- Reset values: state IDLE, cnt 0, `if_rdata`/`mem_rdata` 0, `if_ready`/`mem_ready`/`sram_en`/`sram_we` 0, `sram_addr`/`sram_wdata` 0, `freeze` 0.
- Reset mid-ACCESS or in DONE:
  - Abort at the next edge.
  - `sram_en`/`sram_we` drop.
  - No ready pulse; rdata registers clear.
- All outputs except `freeze` are registered, or decoded purely from registered state.

## Structure

- Shared package `mem_arb_pkg`:
  - state enum (IDLE/ACCESS/DONE);
  - owner encoding (OWN_IF/OWN_MEM);
  - default `SRAM_WAIT`.
- One sub-module: `sram_wait_counter`. It is a loadable down-counter with `load`, `load_val` and `zero`. The FSM, latches and freeze logic stay in the top.

## Test plan

- Fetch only, SRAM_WAIT=3: `if_req`=1 at cycle 0, SRAM word 0x10=0xE3A01005 → `sram_en` cycles 1–3, `if_ready` and `if_rdata`=0xE3A01005 at cycle 4, `freeze` high cycles 0–3.
- Simultaneous `if_req` and `mem_r_en` at cycle 0 → data read served first (`mem_ready` cycle 4), fetch granted cycle 5, `if_ready` cycle 9, `freeze` low at cycle 9.
- Store `mem_w_en`, addr 0x104, wdata 0xDEADBEEF → `sram_we`=1 for 3 cycles with `sram_addr`=0x41; a following load of 0x104 returns 0xDEADBEEF; `mem_rdata` unchanged after the store.
- SRAM_WAIT=1 back-to-back loads → ready at cycles 2 and 5; no cycle with both ready signals high.
- `rst` asserted during the second ACCESS cycle → next cycle IDLE, `sram_en`=0, no ready pulse, rdata registers 0; a fresh request after reset completes normally.
- Request dropped mid-ACCESS → `sram_addr` stays at the latched value, ready still pulses at t+SRAM_WAIT+1, FSM returns to IDLE.
